// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: terminates one master port with INCR write/read bursts
// into an internal word array. Write and read channels run independently.
module axi_slave_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  typedef logic [IDX_W-1:0] idx_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte offset and address bits above the array are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{AWADDR, ARADDR};

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t   w_state, w_next;
  idx_t       w_idx;
  logic [7:0] w_len, w_cnt;
  logic       aw_hs, w_hs, b_hs, w_end;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  // Burst closes on whichever comes first: the AWLEN count or the master's WLAST.
  assign w_end = (w_cnt == w_len) || WLAST;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_end) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_idx <= AWADDR[OFF_W +: IDX_W];
        w_len <= AWLEN;
        w_cnt <= '0;
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 8'd1;
        if (w_end) BRESP <= ((w_cnt == w_len) && WLAST) ? 2'b00 : 2'b10;
      end
    end
  end

  // Array is not reset so contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (w_hs) mem[w_idx] <= WDATA;
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t   r_state, r_next;
  idx_t       r_idx, ar_idx, r_nidx;
  logic [7:0] r_len, r_cnt;
  logic       ar_hs, r_hs;

  assign ar_hs  = ARVALID && ARREADY;
  assign r_hs   = RVALID && RREADY;
  assign ar_idx = ARADDR[OFF_W +: IDX_W];
  assign r_nidx = r_idx + 1'b1;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Fetch uses the pre-edge array value, so a same-edge write is not seen.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RDATA   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_idx <= ar_idx;
        r_len <= ARLEN;
        r_cnt <= '0;
        RDATA <= mem[ar_idx];
        RLAST <= (ARLEN == 8'd0);
      end else if (r_hs && !RLAST) begin
        r_idx <= r_nidx;
        r_cnt <= r_cnt + 8'd1;
        RDATA <= mem[r_nidx];
        RLAST <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: table of write bursts with readback through a
// scoreboard queue, plus stalled-read and mid-burst-reset sequences.
module tb_axi_slave_mem;
  localparam int DW = 64, AW = 32, DEPTH = 256;

  logic          ACLK = 1'b0, ARESETn = 1'b0;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]    AWLEN = '0, ARLEN = '0;
  logic          AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY;
  logic [DW-1:0] WDATA = '0, RDATA;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY = 0, ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int checks = 0, errors = 0;
  logic [DW-1:0] model [DEPTH];

  typedef struct packed {logic [DW-1:0] data; logic last;} rexp_t;
  rexp_t exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    int            wlast_at;  // beat carrying WLAST; > len means never
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    logic [1:0]    resp;
  } wvec_t;
  wvec_t vec[6];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic axi_write(input wvec_t v, input string nm);
    int cyc, beat;
    bit done;
    logic [7:0] idx;
    idx = v.addr[10:3];
    AWADDR = v.addr; AWLEN = 8'(v.len); AWVALID = 1;
    cyc = 0;
    while (!AWREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (!AWREADY) timeout({nm, " aw"});
    @(negedge ACLK);
    AWVALID = 0;
    beat = 0; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      WDATA  = v.base + v.step * DW'(beat);
      WLAST  = (beat == v.wlast_at);
      WVALID = 1;
      if (WREADY) begin
        model[idx] = WDATA;
        idx++;
        done = (beat == v.len) || (beat == v.wlast_at);
        beat++;
      end
      @(negedge ACLK); cyc++;
    end
    WVALID = 0; WLAST = 0;
    if (!done) timeout({nm, " w"});
    check({nm, " bvalid"}, DW'(BVALID), 1);
    check({nm, " wready_off"}, DW'(WREADY), 0);
    check({nm, " bresp"}, DW'(BRESP), DW'(v.resp));
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    check({nm, " bvalid_off"}, DW'(BVALID), 0);
    check({nm, " awready_back"}, DW'(AWREADY), 1);
  endtask

  // pat[p % plen] drives RREADY on successive cycles.
  task automatic axi_read(input logic [AW-1:0] addr, input int len,
                          input logic [15:0] pat, input int plen, input string nm);
    int cyc, p;
    bit done, stalled;
    logic [7:0] idx;
    logic [DW-1:0] sd;
    logic sl, rr;
    rexp_t e;
    idx = addr[10:3];
    for (int b = 0; b <= len; b++) begin
      e.data = model[idx]; e.last = (b == len);
      exp_q.push_back(e);
      idx++;
    end
    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1;
    cyc = 0;
    while (!ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (!ARREADY) timeout({nm, " ar"});
    @(negedge ACLK);
    ARVALID = 0;
    check({nm, " rvalid_lat"}, DW'(RVALID), 1);
    p = 0; cyc = 0; done = 0; stalled = 0; sd = '0; sl = 0; e = '0;
    while (!done && cyc < 200) begin
      rr = pat[p % plen]; p++;
      RREADY = rr;
      if (stalled) begin
        check({nm, " stall_valid"}, DW'(RVALID), 1);
        check({nm, " stall_data"}, RDATA, sd);
        check({nm, " stall_last"}, DW'(RLAST), DW'(sl));
      end
      stalled = 0;
      if (RVALID && rr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra_beat: got %0h want none", nm, RDATA);
        end else begin
          e = exp_q.pop_front();
          check({nm, " rdata"}, RDATA, e.data);
          check({nm, " rlast"}, DW'(RLAST), DW'(e.last));
          done = e.last;
        end
      end else if (RVALID) begin
        stalled = 1; sd = RDATA; sl = RLAST;
      end
      @(negedge ACLK); cyc++;
    end
    RREADY = 0;
    if (!done) timeout({nm, " r"});
    check({nm, " rvalid_off"}, DW'(RVALID), 0);
    check({nm, " arready_back"}, DW'(ARREADY), 1);
    check({nm, " rdata_hold"}, RDATA, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec[0] = '{32'h10,        3, 3,   64'h1,                 64'h1,  2'b00};
    vec[1] = '{32'h100,       3, 3,   64'h700,               64'h1,  2'b00};
    vec[2] = '{32'h100,       3, 1,   64'hA,                 64'h1,  2'b10};
    vec[3] = '{32'h200,       1, 255, 64'hC0,                64'h1,  2'b10};
    vec[4] = '{32'h7F8,       1, 1,   64'h55,                64'h11, 2'b00};
    vec[5] = '{32'h1000_031B, 0, 0,   64'hDEAD_BEEF_0123_4567, 64'h0, 2'b00};

    repeat (5) @(negedge ACLK);
    check("rst awready", DW'(AWREADY), 0);
    check("rst wready",  DW'(WREADY), 0);
    check("rst bvalid",  DW'(BVALID), 0);
    check("rst bresp",   DW'(BRESP), 0);
    check("rst arready", DW'(ARREADY), 0);
    check("rst rvalid",  DW'(RVALID), 0);
    check("rst rlast",   DW'(RLAST), 0);
    check("rst rdata",   RDATA, 0);
    ARESETn = 1;
    @(negedge ACLK);
    check("post_rst awready", DW'(AWREADY), 1);
    check("post_rst arready", DW'(ARREADY), 1);

    for (int i = 0; i < 6; i++) begin
      axi_write(vec[i], $sformatf("v%0d wr", i));
      axi_read(vec[i].addr, vec[i].len, 16'hFFFF, 1, $sformatf("v%0d rd", i));
    end
    // Known spec values, independent of the model.
    check("wrap idx_last", model[255], 64'h55);
    check("wrap idx0", model[0], 64'h66);
    check("early_wlast untouched", model[34], 64'h702);

    axi_read(32'h10, 3, 16'h0069, 7, "stall rd");

    // Reset in the middle of a 4-beat read.
    ARADDR = 32'h10; ARLEN = 8'd3; ARVALID = 1;
    @(negedge ACLK);
    ARVALID = 0; RREADY = 1;
    check("mid_rst beat1", RDATA, 64'h1);
    @(negedge ACLK);
    check("mid_rst beat2", RDATA, 64'h2);
    RREADY = 0;
    #2 ARESETn = 0;
    #1;
    check("mid_rst rvalid", DW'(RVALID), 0);
    check("mid_rst rdata", RDATA, 0);
    check("mid_rst arready", DW'(ARREADY), 0);
    check("mid_rst awready", DW'(AWREADY), 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    check("mid_rst arready_back", DW'(ARREADY), 1);
    exp_q.delete();
    axi_read(32'h10, 3, 16'hFFFF, 1, "after_rst rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
